// File: rtl/multicycle_control.sv
// Main control FSM for the multicycle MIPS datapath; counts retired instructions.
// Optional illegal-instruction trap enabled by defining MC_ILLEGAL_TRAP_EN.
module multicycle_control #(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [5:0]       opcode,
    input  logic [5:0]       funct,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             pc_en,
    output logic             iord,
    output logic             mem_read,
    output logic             mem_write,
    output logic             ir_write,
    output logic             mem_to_reg,
    output logic             reg_dst,
    output logic             reg_write,
    output logic             alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [3:0]       alu_op,
    output logic [1:0]       pc_source,
    output logic [3:0]       state_o,
    output logic [CNT_W-1:0] instr_count,
    output logic             illegal
);

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMRD    = 4'd3,
        MEMWB    = 4'd4,
        MEMWR    = 4'd5,
        RTYPE_EX = 4'd6,
        RTYPE_WB = 4'd7,
        BEQ      = 4'd8,
        JUMP     = 4'd9,
        ADDI_EX  = 4'd10,
`ifdef MC_ILLEGAL_TRAP_EN
        ADDI_WB  = 4'd11,
        TRAP     = 4'd12
`else
        ADDI_WB  = 4'd11
`endif
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [CNT_W-1:0] r_count;
    logic [3:0]       w_rtype_op;

    always_comb begin
        case (funct)
            6'b100010: w_rtype_op = 4'b0110;
            6'b100100: w_rtype_op = 4'b0000;
            6'b100101: w_rtype_op = 4'b0001;
            default:   w_rtype_op = 4'b0010;
        endcase
    end

`ifdef MC_ILLEGAL_TRAP_EN
    logic w_funct_ok;
    logic r_illegal;

    always_comb begin
        w_funct_ok = (funct == 6'b100000) || (funct == 6'b100010) ||
                     (funct == 6'b100100) || (funct == 6'b100101);
    end
`endif

    always_comb begin
        w_next = r_state;
        case (r_state)
            FETCH:    w_next = mem_ready ? DECODE : FETCH;
            DECODE: begin
                case (opcode)
                    6'b100011, 6'b101011: w_next = MEMADR;
                    6'b000000:            w_next = RTYPE_EX;
                    6'b000100:            w_next = BEQ;
                    6'b000010:            w_next = JUMP;
                    6'b001000:            w_next = ADDI_EX;
`ifdef MC_ILLEGAL_TRAP_EN
                    default:              w_next = TRAP;
`else
                    default:              w_next = FETCH;
`endif
                endcase
            end
            MEMADR:   w_next = (opcode == 6'b101011) ? MEMWR : MEMRD;
            MEMRD:    w_next = mem_ready ? MEMWB : MEMRD;
            MEMWR:    w_next = mem_ready ? FETCH : MEMWR;
`ifdef MC_ILLEGAL_TRAP_EN
            RTYPE_EX: w_next = w_funct_ok ? RTYPE_WB : TRAP;
            TRAP:     w_next = TRAP;
`else
            RTYPE_EX: w_next = RTYPE_WB;
`endif
            ADDI_EX:  w_next = ADDI_WB;
            default:  w_next = FETCH;
        endcase
    end

    // Retirement is any arrival in FETCH from elsewhere; TRAP never reaches FETCH.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= FETCH;
            r_count <= '0;
        end else begin
            r_state <= w_next;
            if (r_state != FETCH && w_next == FETCH)
                r_count <= r_count + CNT_W'(1);
        end
    end

`ifdef MC_ILLEGAL_TRAP_EN
    always_ff @(posedge clk) begin
        if (!rst_n)
            r_illegal <= 1'b0;
        else if (w_next == TRAP)
            r_illegal <= 1'b1;
    end
    assign illegal = r_illegal;
`else
    assign illegal = 1'b0;
`endif

    assign state_o     = r_state;
    assign instr_count = r_count;

    // Holding reset forces the idle decode so an abandoned instruction writes nothing.
    always_comb begin
        pc_en      = 1'b0;
        iord       = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        ir_write   = 1'b0;
        mem_to_reg = 1'b0;
        reg_dst    = 1'b0;
        reg_write  = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = 2'b00;
        alu_op     = 4'b0010;
        pc_source  = 2'b00;
        if (rst_n) begin
            case (r_state)
                FETCH: begin
                    mem_read  = 1'b1;
                    alu_src_b = 2'b01;
                    ir_write  = mem_ready;
                    pc_en     = mem_ready;
                end
                DECODE:   alu_src_b = 2'b11;
                MEMADR: begin
                    alu_src_a = 1'b1;
                    alu_src_b = 2'b10;
                end
                MEMRD: begin
                    mem_read = 1'b1;
                    iord     = 1'b1;
                end
                MEMWB: begin
                    mem_to_reg = 1'b1;
                    reg_write  = 1'b1;
                end
                MEMWR: begin
                    mem_write = 1'b1;
                    iord      = 1'b1;
                end
                RTYPE_EX: begin
                    alu_src_a = 1'b1;
                    alu_op    = w_rtype_op;
                end
                RTYPE_WB: begin
                    reg_dst   = 1'b1;
                    reg_write = 1'b1;
                end
                BEQ: begin
                    alu_src_a = 1'b1;
                    alu_op    = 4'b0111;
                    pc_source = 2'b01;
                    pc_en     = zero;
                end
                JUMP: begin
                    pc_source = 2'b10;
                    pc_en     = 1'b1;
                end
                ADDI_EX: begin
                    alu_src_a = 1'b1;
                    alu_src_b = 2'b10;
                end
                ADDI_WB:  reg_write = 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: per-cycle state, control bundle and counter.
// Control bundle order: pc_en iord mem_read mem_write ir_write mem_to_reg reg_dst reg_write alu_src_a alu_src_b alu_op pc_source.
module tb_multicycle_control;

    logic        clk;
    logic        rst_n;
    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic        zero;
    logic        mem_ready;
    logic        pc_en, iord, mem_read, mem_write, ir_write;
    logic        mem_to_reg, reg_dst, reg_write, alu_src_a;
    logic [1:0]  alu_src_b;
    logic [3:0]  alu_op;
    logic [1:0]  pc_source;
    logic [3:0]  state_o;
    logic [31:0] instr_count;
    logic        illegal;
    logic [16:0] w_ctl;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    localparam logic [16:0] C_RST  = 17'b0_0_0_0_0_0_0_0_0_00_0010_00;
    localparam logic [16:0] C_F    = 17'b1_0_1_0_1_0_0_0_0_01_0010_00;
    localparam logic [16:0] C_FS   = 17'b0_0_1_0_0_0_0_0_0_01_0010_00;
    localparam logic [16:0] C_DEC  = 17'b0_0_0_0_0_0_0_0_0_11_0010_00;
    localparam logic [16:0] C_MA   = 17'b0_0_0_0_0_0_0_0_1_10_0010_00;
    localparam logic [16:0] C_MR   = 17'b0_1_1_0_0_0_0_0_0_00_0010_00;
    localparam logic [16:0] C_MWB  = 17'b0_0_0_0_0_1_0_1_0_00_0010_00;
    localparam logic [16:0] C_MW   = 17'b0_1_0_1_0_0_0_0_0_00_0010_00;
    localparam logic [16:0] C_RSUB = 17'b0_0_0_0_0_0_0_0_1_00_0110_00;
    localparam logic [16:0] C_RAND = 17'b0_0_0_0_0_0_0_0_1_00_0000_00;
    localparam logic [16:0] C_RADD = 17'b0_0_0_0_0_0_0_0_1_00_0010_00;
    localparam logic [16:0] C_RWB  = 17'b0_0_0_0_0_0_1_1_0_00_0010_00;
    localparam logic [16:0] C_BEQ1 = 17'b1_0_0_0_0_0_0_0_1_00_0111_01;
    localparam logic [16:0] C_BEQ0 = 17'b0_0_0_0_0_0_0_0_1_00_0111_01;
    localparam logic [16:0] C_J    = 17'b1_0_0_0_0_0_0_0_0_00_0010_10;
    localparam logic [16:0] C_AWB  = 17'b0_0_0_0_0_0_0_1_0_00_0010_00;

    multicycle_control #(.CNT_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct),
        .zero(zero), .mem_ready(mem_ready), .pc_en(pc_en), .iord(iord),
        .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
        .mem_to_reg(mem_to_reg), .reg_dst(reg_dst), .reg_write(reg_write),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
        .pc_source(pc_source), .state_o(state_o), .instr_count(instr_count),
        .illegal(illegal)
    );

    assign w_ctl = {pc_en, iord, mem_read, mem_write, ir_write, mem_to_reg,
                    reg_dst, reg_write, alu_src_a, alu_src_b, alu_op, pc_source};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Apply inputs for one cycle, check the state and combinational controls, then advance.
    task automatic cyc(input string tag, input logic [5:0] op, input logic [5:0] fn,
                       input logic rdy, input logic z, input logic [3:0] st,
                       input logic [16:0] ctl);
        opcode    = op;
        funct     = fn;
        mem_ready = rdy;
        zero      = z;
        #1;
        check({tag, "/state"}, 32'(state_o), 32'(st));
        check({tag, "/ctl"}, 32'(w_ctl), 32'(ctl));
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; opcode = '0; funct = '0; zero = 1'b0; mem_ready = 1'b1;
        @(posedge clk); #1;
        check("rst/state", 32'(state_o), 32'd0);
        check("rst/count", instr_count, 32'd0);
        check("rst/ctl", 32'(w_ctl), 32'(C_RST));
        check("rst/illegal", 32'(illegal), 32'd0);
        @(posedge clk); #1;
        check("rst2/ctl", 32'(w_ctl), 32'(C_RST));
        rst_n = 1'b1;

        // lw: 5 cycles
        cyc("lw.f",  6'b100011, 6'd0, 1'b1, 1'b0, 4'd0, C_F);
        cyc("lw.d",  6'b100011, 6'd0, 1'b1, 1'b0, 4'd1, C_DEC);
        cyc("lw.ma", 6'b100011, 6'd0, 1'b1, 1'b0, 4'd2, C_MA);
        cyc("lw.mr", 6'b100011, 6'd0, 1'b1, 1'b0, 4'd3, C_MR);
        cyc("lw.wb", 6'b100011, 6'd0, 1'b1, 1'b0, 4'd4, C_MWB);
        check("lw/count", instr_count, 32'd1);

        // R-type sub then and
        cyc("sub.f",  6'b000000, 6'b100010, 1'b1, 1'b0, 4'd0, C_F);
        cyc("sub.d",  6'b000000, 6'b100010, 1'b1, 1'b0, 4'd1, C_DEC);
        cyc("sub.ex", 6'b000000, 6'b100010, 1'b1, 1'b0, 4'd6, C_RSUB);
        cyc("sub.wb", 6'b000000, 6'b100010, 1'b1, 1'b0, 4'd7, C_RWB);
        cyc("and.f",  6'b000000, 6'b100100, 1'b1, 1'b0, 4'd0, C_F);
        cyc("and.d",  6'b000000, 6'b100100, 1'b1, 1'b0, 4'd1, C_DEC);
        cyc("and.ex", 6'b000000, 6'b100100, 1'b1, 1'b0, 4'd6, C_RAND);
        cyc("and.wb", 6'b000000, 6'b100100, 1'b1, 1'b0, 4'd7, C_RWB);
        check("rtype/count", instr_count, 32'd3);

        // beq taken, then not taken: 3 cycles each
        cyc("beq1.f", 6'b000100, 6'd0, 1'b1, 1'b1, 4'd0, C_F);
        cyc("beq1.d", 6'b000100, 6'd0, 1'b1, 1'b1, 4'd1, C_DEC);
        cyc("beq1.b", 6'b000100, 6'd0, 1'b1, 1'b1, 4'd8, C_BEQ1);
        cyc("beq0.f", 6'b000100, 6'd0, 1'b1, 1'b0, 4'd0, C_F);
        cyc("beq0.d", 6'b000100, 6'd0, 1'b1, 1'b0, 4'd1, C_DEC);
        cyc("beq0.b", 6'b000100, 6'd0, 1'b1, 1'b0, 4'd8, C_BEQ0);
        check("beq/count", instr_count, 32'd5);

        // sw with 3 stall cycles in MEMWR: 7 cycles total
        cyc("sw.f",  6'b101011, 6'd0, 1'b1, 1'b0, 4'd0, C_F);
        cyc("sw.d",  6'b101011, 6'd0, 1'b1, 1'b0, 4'd1, C_DEC);
        cyc("sw.ma", 6'b101011, 6'd0, 1'b1, 1'b0, 4'd2, C_MA);
        for (int i = 0; i < 3; i++)
            cyc("sw.stall", 6'b101011, 6'd0, 1'b0, 1'b0, 4'd5, C_MW);
        cyc("sw.mw", 6'b101011, 6'd0, 1'b1, 1'b0, 4'd5, C_MW);
        check("sw/count", instr_count, 32'd6);

        // fetch stall, then jump
        cyc("j.fs", 6'b000010, 6'd0, 1'b0, 1'b0, 4'd0, C_FS);
        cyc("j.f",  6'b000010, 6'd0, 1'b1, 1'b0, 4'd0, C_F);
        cyc("j.d",  6'b000010, 6'd0, 1'b1, 1'b0, 4'd1, C_DEC);
        cyc("j.j",  6'b000010, 6'd0, 1'b1, 1'b0, 4'd9, C_J);
        check("j/count", instr_count, 32'd7);

        // addi
        cyc("addi.f",  6'b001000, 6'd0, 1'b1, 1'b0, 4'd0, C_F);
        cyc("addi.d",  6'b001000, 6'd0, 1'b1, 1'b0, 4'd1, C_DEC);
        cyc("addi.ex", 6'b001000, 6'd0, 1'b1, 1'b0, 4'd10, C_MA);
        cyc("addi.wb", 6'b001000, 6'd0, 1'b1, 1'b0, 4'd11, C_AWB);
        check("addi/count", instr_count, 32'd8);

        // reset in MEMWB abandons the write
        cyc("lwr.f",  6'b100011, 6'd0, 1'b1, 1'b0, 4'd0, C_F);
        cyc("lwr.d",  6'b100011, 6'd0, 1'b1, 1'b0, 4'd1, C_DEC);
        cyc("lwr.ma", 6'b100011, 6'd0, 1'b1, 1'b0, 4'd2, C_MA);
        cyc("lwr.mr", 6'b100011, 6'd0, 1'b1, 1'b0, 4'd3, C_MR);
        rst_n = 1'b0;
        #1;
        check("midrst/state", 32'(state_o), 32'd4);
        check("midrst/ctl", 32'(w_ctl), 32'(C_RST));
        @(posedge clk); #1;
        check("midrst/state2", 32'(state_o), 32'd0);
        check("midrst/count", instr_count, 32'd0);
        rst_n = 1'b1;

`ifndef MC_ILLEGAL_TRAP_EN
        // unknown funct executes as ADD
        cyc("rx.f",  6'b000000, 6'b101010, 1'b1, 1'b0, 4'd0, C_F);
        cyc("rx.d",  6'b000000, 6'b101010, 1'b1, 1'b0, 4'd1, C_DEC);
        cyc("rx.ex", 6'b000000, 6'b101010, 1'b1, 1'b0, 4'd6, C_RADD);
        cyc("rx.wb", 6'b000000, 6'b101010, 1'b1, 1'b0, 4'd7, C_RWB);
        check("rx/count", instr_count, 32'd1);
        // unknown opcode is a retired no-op
        cyc("ill.f", 6'b111111, 6'd0, 1'b1, 1'b0, 4'd0, C_F);
        cyc("ill.d", 6'b111111, 6'd0, 1'b1, 1'b0, 4'd1, C_DEC);
        cyc("ill.back", 6'b000000, 6'b100000, 1'b0, 1'b0, 4'd0, C_FS);
        check("ill/count", instr_count, 32'd2);
        check("ill/illegal", 32'(illegal), 32'd0);
`else
        cyc("ill.f", 6'b111111, 6'd0, 1'b1, 1'b0, 4'd0, C_F);
        cyc("ill.d", 6'b111111, 6'd0, 1'b1, 1'b0, 4'd1, C_DEC);
        for (int i = 0; i < 3; i++) begin
            cyc("trap", 6'b000000, 6'd0, 1'b1, 1'b0, 4'd12, C_RST);
            check("trap/illegal", 32'(illegal), 32'd1);
            check("trap/count", instr_count, 32'd0);
        end
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        check("trap/exit", 32'(state_o), 32'd0);
        check("trap/clr", 32'(illegal), 32'd0);
        cyc("rx.f",  6'b000000, 6'b101010, 1'b1, 1'b0, 4'd0, C_F);
        cyc("rx.d",  6'b000000, 6'b101010, 1'b1, 1'b0, 4'd1, C_DEC);
        cyc("rx.ex", 6'b000000, 6'b101010, 1'b1, 1'b0, 4'd6, C_RADD);
        check("rx/trap", 32'(state_o), 32'd12);
        check("rx/illegal", 32'(illegal), 32'd1);
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
